// File: rtl/hazard_sched.sv
// hazard_sched: pipeline sequencer for the 8-bit, 16-register 5-stage core.
// Drives stage-register load enables, IF/ID flush, ID/EX bubble and EX
// operand forwarding selects; detects load-use, taken-branch and dmem waits.
//
// Ports (input):
//   clk, rst_n                      clock, async active-low reset
//   id_rs1/id_rs2, id_use1/id_use2  ID sources and their use flags
//   ex_rs1/ex_rs2                   EX sources (forwarding compare)
//   ex_wreg, ex_regwrt, ex_memrd    EX destination, write and load flags
//   mem_wreg, mem_regwrt            MEM destination and write flag
//   wb_wreg, wb_regwrt              WB destination and write flag
//   branch_taken                    branch resolved taken in EX
//   dmem_req, dmem_ack              MEM access outstanding / completing
// Ports (output):
//   pc_we, ifid_we, idex_we, exmem_we, memwb_we   stage load enables
//   ifid_flush, idex_bubble                       NOP insertion
//   fwd_a, fwd_b       00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall_cnt          saturating count of cycles with pc_we=0
//   mem_err            sticky dmem timeout flag
//
// Configuration macro: HAZARD_SCHED_FWD_EN
//   defined   : forwarding active, only load-use stalls
//   undefined : no forwarding, any RAW on ex/mem/wb stalls ID

module hazard_sched #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       id_rs1,
    input  logic [3:0]       id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [3:0]       ex_rs1,
    input  logic [3:0]       ex_rs2,
    input  logic [3:0]       ex_wreg,
    input  logic             ex_regwrt,
    input  logic             ex_memrd,
    input  logic [3:0]       mem_wreg,
    input  logic             mem_regwrt,
    input  logic [3:0]       wb_wreg,
    input  logic             wb_regwrt,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mem_err
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

    state_e            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [WC_W-1:0]   wc_inc;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic waiting;
    logic stall_raw;
    logic br_sel;
    logic stl_sel;
    logic run_sel;

    // Register 0 is hard-wired zero, so it never creates a dependency.
    function automatic logic raw_hit(
        input logic [3:0] src,
        input logic       used,
        input logic [3:0] dst,
        input logic       wr
    );
        return used && wr && (dst != 4'd0) && (src == dst);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [3:0] src);
        if (mem_regwrt && (mem_wreg != 4'd0) && (mem_wreg == src))
            return 2'b01;
        else if (wb_regwrt && (wb_wreg != 4'd0) && (wb_wreg == src))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    logic ld_use;
    assign ld_use = ex_memrd &&
                    (raw_hit(id_rs1, id_use1, ex_wreg, ex_regwrt) ||
                     raw_hit(id_rs2, id_use2, ex_wreg, ex_regwrt));

`ifdef HAZARD_SCHED_FWD_EN
    // Set after a load-use bubble was issued: the load has now left EX in
    // the real pipeline, so the same dependency must not stall twice.
    logic ldst_q, ldst_d;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    assign stall_raw = ld_use && !ldst_q;
    assign fwd_a_raw = fwd_sel(ex_rs1);
    assign fwd_b_raw = fwd_sel(ex_rs2);
`else
    logic [1:0] fwd_a_raw, fwd_b_raw;
    logic       unused_fwd_srcs;

    // Without forwarding every RAW hazard holds ID until the producer retires.
    assign stall_raw =
        ld_use ||
        raw_hit(id_rs1, id_use1, ex_wreg, ex_regwrt) ||
        raw_hit(id_rs2, id_use2, ex_wreg, ex_regwrt) ||
        raw_hit(id_rs1, id_use1, mem_wreg, mem_regwrt) ||
        raw_hit(id_rs2, id_use2, mem_wreg, mem_regwrt) ||
        raw_hit(id_rs1, id_use1, wb_wreg, wb_regwrt) ||
        raw_hit(id_rs2, id_use2, wb_wreg, wb_regwrt);
    assign fwd_a_raw = 2'b00;
    assign fwd_b_raw = 2'b00;
    assign unused_fwd_srcs = ^{ex_rs1, ex_rs2, fwd_sel(4'd0)};
`endif

    // A wait persists in MEM_WAIT even if req drops; only ack releases it,
    // and the ack cycle itself already runs normally.
    assign waiting = ((state_q == MEM_WAIT) || dmem_req) && !dmem_ack;

    assign br_sel  = rst_n && !waiting && branch_taken;
    assign stl_sel = rst_n && !waiting && !branch_taken && stall_raw;
    assign run_sel = rst_n && !waiting && !branch_taken && !stall_raw;

    assign wc_inc = (wait_cnt_q == WC_MAX) ? WC_MAX : wait_cnt_q + 1'b1;

    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_we     = 1'b0;
        exmem_we    = 1'b0;
        memwb_we    = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        state_d     = RUN;
        wait_cnt_d  = '0;
        mem_err_d   = mem_err_q;
`ifdef HAZARD_SCHED_FWD_EN
        ldst_d      = 1'b0;
`endif

        if (rst_n) begin
            fwd_a = fwd_a_raw;
            fwd_b = fwd_b_raw;
        end

        unique case (1'b1)
            !rst_n: begin
            end
            rst_n && waiting: begin
                state_d    = MEM_WAIT;
                wait_cnt_d = wc_inc;
                if (wc_inc == WC_MAX)
                    mem_err_d = 1'b1;
`ifdef HAZARD_SCHED_FWD_EN
                ldst_d = ldst_q;
`endif
            end
            br_sel: begin
                // Flush supersedes any simultaneous load-use stall.
                pc_we       = 1'b1;
                ifid_we     = 1'b1;
                idex_we     = 1'b1;
                exmem_we    = 1'b1;
                memwb_we    = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end
            stl_sel: begin
                idex_we     = 1'b1;
                exmem_we    = 1'b1;
                memwb_we    = 1'b1;
                idex_bubble = 1'b1;
`ifdef HAZARD_SCHED_FWD_EN
                ldst_d = 1'b1;
`endif
            end
            run_sel: begin
                pc_we    = 1'b1;
                ifid_we  = 1'b1;
                idex_we  = 1'b1;
                exmem_we = 1'b1;
                memwb_we = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
`ifdef HAZARD_SCHED_FWD_EN
            ldst_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
            if (!pc_we && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + 1'b1;
`ifdef HAZARD_SCHED_FWD_EN
            ldst_q     <= ldst_d;
`endif
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign mem_err   = mem_err_q;

endmodule
